msk_rnd_trivium_src: RTL and testbench

- Masking-randomness source: Trivium keystream generator feeding the fresh-randomness bus (`rnd`) of HPC3 and other gadgets. It is the producer end of the gadgets' randomness port.
- Provides RND_W fresh bits per accepted transfer under a valid/ready handshake. No bit is ever delivered twice.
- Seeded serially from an external TRNG/host (80-bit key + 80-bit IV). Sits at the top of masked cores, e.g. fanned out to every gadget's `rnd` slice.

---
 rtl/msk_rnd_pkg.sv | 39 +++
 rtl/trivium_step_n.sv | 39 +++
 rtl/msk_rnd_trivium_src.sv | 135 +++++++++++++
 tb/tb_msk_rnd_trivium_src.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_rnd_pkg.sv
// Shared constants for the Trivium masking-randomness source: register geometry,
// tap positions (1-based, as in the cipher description), FSM encoding and sizing helpers.
package msk_rnd_pkg;

  localparam int TRIV_STATE = 288;
  localparam int KEY_W      = 80;
  localparam int IV_W       = 80;
  localparam int SEED_TOT   = KEY_W + IV_W;

  // Register A spans s1..s93, B spans s94..s177, C spans s178..s288.
  localparam int REG_A_LEN  = 93;
  localparam int REG_B_END  = 177;

  localparam int T1_A = 66,  T1_B = 93,  T1_AND0 = 91,  T1_AND1 = 92,  T1_X = 171;
  localparam int T2_A = 162, T2_B = 177, T2_AND0 = 175, T2_AND1 = 176, T2_X = 264;
  localparam int T3_A = 243, T3_B = 288, T3_AND0 = 286, T3_AND1 = 287, T3_X = 69;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_SEED     = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_RUN      = 2'd3
  } fsm_e;

  function automatic int warm_cycles(input int warmup, input int rnd_w);
    return (warmup + rnd_w - 1) / rnd_w;
  endfunction

  // One counter serves both the chunk index (0..n_chunks) and the warm-up cycle count.
  function automatic int cnt_width(input int n_chunks, input int warm_cyc);
    int mx;
    int w;
    mx = (n_chunks > warm_cyc - 1) ? n_chunks : warm_cyc - 1;
    w  = 1;
    while ((1 << w) <= mx) w++;
    return w;
  endfunction

endpackage

// File: rtl/trivium_step_n.sv
// N Trivium steps chained combinationally; keystream bit of step k lands in z_o[k].
module trivium_step_n
  import msk_rnd_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [TRIV_STATE-1:0] state_i,
  output logic [TRIV_STATE-1:0] state_o,
  output logic [N-1:0]          z_o
);

  logic [TRIV_STATE-1:0] s;
  logic [N-1:0]          z;
  logic                  t1, t2, t3;

  // Bit i-1 of the vector holds s_i.
  always_comb begin
    s  = state_i;
    z  = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int k = 0; k < N; k++) begin
      t1   = s[T1_A-1] ^ s[T1_B-1];
      t2   = s[T2_A-1] ^ s[T2_B-1];
      t3   = s[T3_A-1] ^ s[T3_B-1];
      z[k] = t1 ^ t2 ^ t3;
      t1   = t1 ^ (s[T1_AND0-1] & s[T1_AND1-1]) ^ s[T1_X-1];
      t2   = t2 ^ (s[T2_AND0-1] & s[T2_AND1-1]) ^ s[T2_X-1];
      t3   = t3 ^ (s[T3_AND0-1] & s[T3_AND1-1]) ^ s[T3_X-1];
      s    = {s[TRIV_STATE-2:REG_B_END], t2,
              s[REG_B_END-2:REG_A_LEN], t1,
              s[REG_A_LEN-2:0], t3};
    end
    state_o = s;
    z_o     = z;
  end

endmodule

// File: rtl/msk_rnd_trivium_src.sv
// Trivium keystream source for gadget fresh randomness: serial key/IV seeding,
// discarded warm-up, then RND_W-bit words under a valid/ready handshake.
module msk_rnd_trivium_src
  import msk_rnd_pkg::*;
#(
  parameter int RND_W  = 32,
  parameter int SEED_W = 32,
  parameter int WARMUP = 1152
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              reseed,
  output logic [RND_W-1:0]  rnd_out,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy
);

  localparam int N_CHUNKS = SEED_TOT / SEED_W;
  localparam int WARM_CYC = warm_cycles(WARMUP, RND_W);
  localparam int CNT_W    = cnt_width(N_CHUNKS, WARM_CYC);
  localparam logic [CNT_W-1:0] CHUNKS_ALL = CNT_W'(N_CHUNKS);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARM_CYC - 1);

  fsm_e                  fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEED_TOT-1:0]   seed_buf_q, seed_buf_d;
  logic [TRIV_STATE-1:0] st_q, st_d, st_step, st_load;
  logic [RND_W-1:0]      rnd_q, rnd_d, z_step;
  logic                  rnd_valid_q, rnd_valid_d;
  logic                  seed_full, seed_hs, warm_done, rnd_fill;

  trivium_step_n #(.N(RND_W)) u_step (
    .state_i (st_q),
    .state_o (st_step),
    .z_o     (z_step)
  );

  // Counter parked at N_CHUNKS marks the one-cycle state-load slot.
  assign seed_full = (cnt_q == CHUNKS_ALL);
  assign warm_done = (cnt_q == WARM_LAST);
  assign seed_hs   = seed_valid & seed_ready;
  // Fill rnd_out once on entry to RUN (priming), then on every accepted word.
  assign rnd_fill  = (fsm_q == ST_RUN) && (!rnd_valid_q || rnd_ready);

  always_comb begin
    st_load                      = '0;
    st_load[KEY_W-1:0]           = seed_buf_q[KEY_W-1:0];
    st_load[REG_A_LEN +: IV_W]   = seed_buf_q[SEED_TOT-1:KEY_W];
    st_load[TRIV_STATE-1 -: 3]   = 3'b111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_UNSEEDED;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    if (reseed) begin
      fsm_d = ST_SEED;
    end else begin
      case (fsm_q)
        ST_SEED:   if (seed_full) fsm_d = ST_WARMUP;
        ST_WARMUP: if (warm_done) fsm_d = ST_RUN;
        default:   fsm_d = fsm_q;
      endcase
    end
  end

  always_comb begin
    seed_ready = (fsm_q == ST_SEED) && !seed_full;
    busy       = (fsm_q == ST_SEED) || (fsm_q == ST_WARMUP);
    rnd_valid  = rnd_valid_q;
    rnd_out    = rnd_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    seed_buf_d  = seed_buf_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    rnd_valid_d = rnd_valid_q;
    if (reseed) begin
      cnt_d       = '0;
      rnd_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_SEED: begin
          if (seed_hs) begin
            // Chunks enter at the top so chunk 0 ends up at bit 0.
            seed_buf_d = (seed_buf_q >> SEED_W) |
                         (SEED_TOT'(seed_in) << (SEED_TOT - SEED_W));
            cnt_d      = cnt_q + CNT_W'(1);
          end else if (seed_full) begin
            st_d  = st_load;
            cnt_d = '0;
          end
        end
        ST_WARMUP: begin
          st_d  = st_step;
          cnt_d = warm_done ? '0 : cnt_q + CNT_W'(1);
        end
        ST_RUN: begin
          if (rnd_fill) begin
            rnd_d       = z_step;
            st_d        = st_step;
            rnd_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      seed_buf_q  <= '0;
      st_q        <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      seed_buf_q  <= seed_buf_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

endmodule

// File: tb/tb_msk_rnd_trivium_src.sv
// Bench for msk_rnd_trivium_src: scripted control table, then randomized streams
// compared with a bit-serial Trivium reference model.
module tb_msk_rnd_trivium_src;

  localparam int RND_W  = 32;
  localparam int SEED_W = 32;
  localparam int WARMUP = 1152;
  localparam int NCH    = 160 / SEED_W;
  localparam int WARM_STEPS = ((WARMUP + RND_W - 1) / RND_W) * RND_W;
  localparam int LAT    = 2 + (WARMUP + RND_W - 1) / RND_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SEED_W-1:0] seed_in = '0;
  logic              seed_valid = 1'b0;
  logic              seed_ready;
  logic              reseed = 1'b0;
  logic [RND_W-1:0]  rnd_out;
  logic              rnd_valid;
  logic              rnd_ready = 1'b0;
  logic              busy;

  msk_rnd_trivium_src #(.RND_W(RND_W), .SEED_W(SEED_W), .WARMUP(WARMUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .reseed     (reseed),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: s[1..288] as plain bit array, one step per call.
  bit ms [1:288];

  task automatic model_step(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 1; i--) ms[i] = ms[i-1];
    ms[1]   = t3;
    ms[94]  = t1;
    ms[178] = t2;
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] iv);
    bit z;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = iv[i-1];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    for (int i = 0; i < WARM_STEPS; i++) model_step(z);
  endtask

  task automatic model_word(output logic [RND_W-1:0] w);
    bit z;
    for (int k = 0; k < RND_W; k++) begin
      model_step(z);
      w[k] = z;
    end
  endtask

  logic [RND_W-1:0] exp_q[$];
  logic [RND_W-1:0] ref_q[$];

  task automatic fill_exp(input logic [79:0] k, input logic [79:0] iv, input int nw);
    logic [RND_W-1:0] w;
    exp_q.delete();
    model_load(k, iv);
    for (int i = 0; i < nw; i++) begin
      model_word(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_feed(input logic [79:0] k, input logic [79:0] iv, input int maxgap);
    logic [159:0] sd;
    logic         acc;
    int           guard;
    sd = {iv, k};
    for (int c = 0; c < NCH; c++) begin
      repeat ($urandom_range(0, maxgap)) begin
        seed_valid = 1'b0;
        seed_in    = SEED_W'($urandom);
        tick();
      end
      seed_valid = 1'b1;
      seed_in    = sd[c*SEED_W +: SEED_W];
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        acc = seed_ready;
        tick();
        guard++;
      end
      if (!acc) chk("seed_accept", 64'(acc), 64'(1));
    end
    seed_valid = 1'b0;
  endtask

  // Called right after the edge that took the last chunk; noise on seed_valid must not matter.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!rnd_valid && n < 200) begin
      seed_valid = 1'($urandom_range(0, 1));
      seed_in    = SEED_W'($urandom);
      tick();
      n++;
    end
    seed_valid = 1'b0;
    chk(name, 64'(n), 64'(LAT));
    chk({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic run_stream(input string name, input int nw, input bit rand_rdy);
    int  idx, cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < nw && cyc < nw * 8 + 50) begin
      chk({name, "_valid"}, 64'(rnd_valid), 64'(1));
      chk({name, "_word"}, 64'(rnd_out), 64'(exp_q[idx]));
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rnd_ready = rdy;
      if (rand_rdy) begin
        seed_valid = 1'($urandom_range(0, 1));
        seed_in    = SEED_W'($urandom);
        chk({name, "_seed_ready"}, 64'(seed_ready), 64'(0));
      end
      tick();
      if (rdy) idx++;
      cyc++;
    end
    rnd_ready  = 1'b0;
    seed_valid = 1'b0;
    if (idx < nw) chk({name, "_timeout"}, 64'(idx), 64'(nw));
  endtask

  task automatic pulse_reseed(input string name);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'(1));
    chk({name, "_seed_ready"}, 64'(seed_ready), 64'(1));
    chk({name, "_rnd_valid"}, 64'(rnd_valid), 64'(0));
  endtask

  typedef struct {
    logic              rs;
    logic              sv;
    logic [SEED_W-1:0] sin;
    logic              e_busy;
    logic              e_sr;
    logic              e_rv;
  } row_t;

  row_t tbl [11];

  initial begin
    logic [79:0] k, iv;

    // Key = IV = 0; garbage rides on every cycle that must not capture a chunk.
    tbl[0]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0};

    #12;
    chk("rst_seed_ready", 64'(seed_ready), 64'(0));
    chk("rst_rnd_valid",  64'(rnd_valid),  64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_rnd_out",    64'(rnd_out),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      reseed     = tbl[i].rs;
      seed_valid = tbl[i].sv;
      seed_in    = tbl[i].sin;
      tick();
      chk($sformatf("tbl%0d_busy", i),       64'(busy),       64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_seed_ready", i), 64'(seed_ready), 64'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_rnd_valid", i),  64'(rnd_valid),  64'(tbl[i].e_rv));
    end
    reseed     = 1'b0;
    seed_valid = 1'b0;
    wait_valid("zero_latency");

    fill_exp('0, '0, 1000);
    ref_q = exp_q;
    run_stream("cont", 1000, 1'b0);

    // Reseed with a coinciding handshake, then idle SEED before gapped chunks.
    rnd_ready = 1'b1;
    pulse_reseed("reseed_run");
    rnd_ready = 1'b0;
    repeat (20) begin
      seed_valid = 1'b0;
      seed_in    = SEED_W'($urandom);
      tick();
    end
    chk("idle_seed_ready", 64'(seed_ready), 64'(1));
    chk("idle_busy",       64'(busy),       64'(1));
    seed_feed('0, '0, 3);
    wait_valid("gap_latency");
    exp_q = ref_q;
    run_stream("toggle", 300, 1'b1);

    // Reseed ten cycles into warm-up, then key=1, IV=0xFFFF.
    pulse_reseed("reseed_pre");
    k  = {16'($urandom), $urandom, $urandom};
    iv = {16'($urandom), $urandom, $urandom};
    seed_feed(k, iv, 2);
    repeat (10) tick();
    chk("warm_busy", 64'(busy), 64'(1));
    pulse_reseed("reseed_warm");
    seed_feed(80'h1, 80'hFFFF, 2);
    wait_valid("k1_latency");
    fill_exp(80'h1, 80'hFFFF, 200);
    run_stream("k1", 200, 1'b1);

    pulse_reseed("reseed_rand");
    k  = {16'($urandom), $urandom, $urandom};
    iv = {16'($urandom), $urandom, $urandom};
    seed_feed(k, iv, 2);
    wait_valid("rand_latency");
    fill_exp(k, iv, 100);
    run_stream("rand", 100, 1'b1);

    // Asynchronous reset between edges while in RUN.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rnd_valid",  64'(rnd_valid),  64'(0));
    chk("arst_busy",       64'(busy),       64'(0));
    chk("arst_seed_ready", 64'(seed_ready), 64'(0));
    chk("arst_rnd_out",    64'(rnd_out),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      seed_valid = 1'b1;
      seed_in    = SEED_W'($urandom);
      tick();
      chk("post_rst_busy",       64'(busy),       64'(0));
      chk("post_rst_seed_ready", 64'(seed_ready), 64'(0));
      chk("post_rst_rnd_valid",  64'(rnd_valid),  64'(0));
    end
    seed_valid = 1'b0;
    pulse_reseed("reseed_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
